// File: rtl/mem_stage_pkg.sv
// Shared rv32i types for the memory stage: control word, funct3 encodings
// and the memory-stage FSM state.
package mem_stage_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    // Store codes match the low bits of the load codes, so one width
    // decode serves both directions.
    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
    } rv32i_control_word;

endpackage

// File: rtl/mem_stage_align.sv
// Combinational data-memory alignment: funct3 + low address bits + store
// data -> byte enable, lane-shifted write data, misaligned flag.
// Macro MEM_MISALIGN_CHECK_EN: when defined, misalign_o flags word accesses
// with addr[1:0]!=0 and half accesses with addr[0]=1; otherwise tied 0.
// Ports:
//   funct3_i   [2:0]  access width/sign code
//   addr_lo_i  [1:0]  byte offset within the word
//   rs2_i      [31:0] store data
//   be_o       [3:0]  byte enable (half at offset 3 truncates to 4'b1000)
//   wdata_o    [31:0] rs2_i shifted into its byte lane
//   misalign_o        misaligned access flag
import mem_stage_pkg::*;

module mem_stage_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    logic mis_raw;

    always_comb begin
        be_o    = 4'b1111;
        mis_raw = 1'b0;
        case (funct3_i)
            lb, lbu: begin
                be_o    = 4'b0001 << addr_lo_i;
            end
            lh, lhu: begin
                be_o    = 4'b0011 << addr_lo_i;
                mis_raw = addr_lo_i[0];
            end
            default: begin
                be_o    = 4'b1111;
                mis_raw = |addr_lo_i;
            end
        endcase
    end

    assign wdata_o = rs2_i << {addr_lo_i, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_o = mis_raw;
`else
    logic unused_mis;
    assign unused_mis = mis_raw;
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage plus MEM/WB pipeline register. Drives the data-memory port
// from the EX/MEM bundle, stalls upstream until dmem_resp_i, and registers
// the bundle, byte enable and raw read word for write-back.
// Macro MEM_MISALIGN_CHECK_EN: misaligned accesses are suppressed and
// reported on misalign_o instead of being issued.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   ex_valid_i, flush_i           bundle valid, kill instruction in MEM
//   pc_i .. br_en_i               EX/MEM bundle
//   stall_o                       hold EX/MEM and upstream
//   dmem_*_o / dmem_*_i           data-memory request / response
//   wb_valid_o .. misalign_o      MEM/WB register outputs
//
// state | meaning
// IDLE  | no access outstanding; new request issues combinationally
// BUSY  | request held, waiting for dmem_resp_i
import mem_stage_pkg::*;

module mem_stage (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic              flush_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       pc_plus4_i,
    input  logic [31:0]       instruction_i,
    input  rv32i_control_word ctrl_word_i,
    input  logic [31:0]       alu_i,
    input  logic [31:0]       rs2_i,
    input  logic [31:0]       br_en_i,
    output logic              stall_o,
    output logic              dmem_read_o,
    output logic              dmem_write_o,
    output logic [31:0]       dmem_address_o,
    output logic [3:0]        dmem_byte_enable_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_resp_i,
    output logic              wb_valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic [31:0]       instruction_o,
    output logic [31:0]       alu_o,
    output logic [31:0]       br_en_o,
    output rv32i_control_word ctrl_word_o,
    output logic [3:0]        mem_byte_enable_o,
    output logic [31:0]       r_data_o,
    output logic              misalign_o
);

    mem_state_t state_q, state_d;
    logic       kill_q, kill_d;
    logic       mem_op, misal, align_mis, req, wb_load;
    logic [3:0] be;

    mem_stage_align u_align (
        .funct3_i   (ctrl_word_i.funct3),
        .addr_lo_i  (alu_i[1:0]),
        .rs2_i      (rs2_i),
        .be_o       (be),
        .wdata_o    (dmem_wdata_o),
        .misalign_o (align_mis)
    );

    assign mem_op = ex_valid_i & (ctrl_word_i.mem_read | ctrl_word_i.mem_write);
    assign misal  = mem_op & align_mis;

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        req     = 1'b0;
        wb_load = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so the port goes quiet the moment reset asserts.
                req     = rst_n & mem_op & ~flush_i & ~misal;
                wb_load = ex_valid_i & ~flush_i & ~(req & ~dmem_resp_i);
                if (req & ~dmem_resp_i)
                    state_d = BUSY;
            end
            BUSY: begin
                req = rst_n;
                if (dmem_resp_i) begin
                    // A flush here cannot abort the access; the result is dropped.
                    wb_load = ~kill_q & ~flush_i;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o            = req & ~dmem_resp_i;
    assign dmem_read_o        = req & ctrl_word_i.mem_read;
    assign dmem_write_o       = req & ctrl_word_i.mem_write;
    assign dmem_address_o     = {alu_i[31:2], 2'b00};
    assign dmem_byte_enable_o = be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            kill_q            <= 1'b0;
            wb_valid_o        <= 1'b0;
            pc_o              <= '0;
            pc_plus4_o        <= '0;
            instruction_o     <= '0;
            alu_o             <= '0;
            br_en_o           <= '0;
            ctrl_word_o       <= '0;
            mem_byte_enable_o <= '0;
            r_data_o          <= '0;
            misalign_o        <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (wb_load) begin
                wb_valid_o                 <= 1'b1;
                pc_o                       <= pc_i;
                pc_plus4_o                 <= pc_plus4_i;
                instruction_o              <= instruction_i;
                alu_o                      <= alu_i;
                br_en_o                    <= br_en_i;
                ctrl_word_o                <= ctrl_word_i;
                ctrl_word_o.load_regfile   <= ctrl_word_i.load_regfile & ~misal;
                mem_byte_enable_o          <= be;
                r_data_o                   <= (req & ctrl_word_i.mem_read) ? dmem_rdata_i : 32'h0;
                misalign_o                 <= misal;
            end else begin
                wb_valid_o        <= 1'b0;
                pc_o              <= '0;
                pc_plus4_o        <= '0;
                instruction_o     <= '0;
                alu_o             <= '0;
                br_en_o           <= '0;
                ctrl_word_o       <= '0;
                mem_byte_enable_o <= '0;
                r_data_o          <= '0;
                misalign_o        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
import mem_stage_pkg::*;

module tb_mem_stage;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid_i, flush_i;
    logic [31:0]       pc_i, pc_plus4_i, instruction_i, alu_i, rs2_i, br_en_i;
    rv32i_control_word ctrl_word_i;
    logic              stall_o, dmem_read_o, dmem_write_o;
    logic [31:0]       dmem_address_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]        dmem_byte_enable_o;
    logic              dmem_resp_i;
    logic              wb_valid_o;
    logic [31:0]       pc_o, pc_plus4_o, instruction_o, alu_o, br_en_o, r_data_o;
    rv32i_control_word ctrl_word_o;
    logic [3:0]        mem_byte_enable_o;
    logic              misalign_o;

    mem_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid_i         (ex_valid_i),
        .flush_i            (flush_i),
        .pc_i               (pc_i),
        .pc_plus4_i         (pc_plus4_i),
        .instruction_i      (instruction_i),
        .ctrl_word_i        (ctrl_word_i),
        .alu_i              (alu_i),
        .rs2_i              (rs2_i),
        .br_en_i            (br_en_i),
        .stall_o            (stall_o),
        .dmem_read_o        (dmem_read_o),
        .dmem_write_o       (dmem_write_o),
        .dmem_address_o     (dmem_address_o),
        .dmem_byte_enable_o (dmem_byte_enable_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_rdata_i       (dmem_rdata_i),
        .dmem_resp_i        (dmem_resp_i),
        .wb_valid_o         (wb_valid_o),
        .pc_o               (pc_o),
        .pc_plus4_o         (pc_plus4_o),
        .instruction_o      (instruction_o),
        .alu_o              (alu_o),
        .br_en_o            (br_en_o),
        .ctrl_word_o        (ctrl_word_o),
        .mem_byte_enable_o  (mem_byte_enable_o),
        .r_data_o           (r_data_o),
        .misalign_o         (misalign_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr, n_rd, n_stall, n_wb;
    logic [3:0]  be0;
    logic [31:0] wd0, ad0;
    rv32i_control_word cw_sw, cw_sb, cw_lh, cw_lw, cw_add;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word mk_cw(input logic [6:0] op, input logic [2:0] f3,
                                                input logic rd, input logic wr, input logic ld);
        rv32i_control_word c;
        c.opcode = op; c.funct3 = f3; c.mem_read = rd; c.mem_write = wr; c.load_regfile = ld;
        return c;
    endfunction

    task automatic idle_inputs();
        ex_valid_i = 0; flush_i = 0; ctrl_word_i = '0; alu_i = 0; rs2_i = 0;
        pc_i = 0; pc_plus4_i = 0; instruction_i = 0; br_en_i = 0;
        dmem_resp_i = 0; dmem_rdata_i = 0;
    endtask

    task automatic set_instr(input rv32i_control_word cw, input logic [31:0] addr,
                             input logic [31:0] rs2v, input logic [31:0] pcv);
        ex_valid_i = 1; ctrl_word_i = cw; alu_i = addr; rs2_i = rs2v;
        pc_i = pcv; pc_plus4_i = pcv + 32'd4; instruction_i = pcv ^ 32'h13; br_en_i = 0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    // Holds one access for lat wait cycles, then responds; ends with idle inputs.
    task automatic issue(input rv32i_control_word cw, input logic [31:0] addr, input logic [31:0] rs2v,
                         input logic [31:0] pcv, input int lat, input logic [31:0] rd);
        n_wr = 0; n_rd = 0; n_stall = 0; n_wb = 0;
        set_instr(cw, addr, rs2v, pcv);
        for (int k = 0; k <= lat; k++) begin
            dmem_resp_i  = (k == lat);
            dmem_rdata_i = (k == lat) ? rd : 32'h0;
            @(negedge clk);
            n_wr += int'(dmem_write_o); n_rd += int'(dmem_read_o);
            n_stall += int'(stall_o); n_wb += int'(wb_valid_o);
            if (k == 0) begin
                be0 = dmem_byte_enable_o; wd0 = dmem_wdata_o; ad0 = dmem_address_o;
            end
            next();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cw_sw  = mk_cw(7'b0100011, 3'b010, 1'b0, 1'b1, 1'b0);
        cw_sb  = mk_cw(7'b0100011, 3'b000, 1'b0, 1'b1, 1'b0);
        cw_lh  = mk_cw(7'b0000011, 3'b001, 1'b1, 1'b0, 1'b1);
        cw_lw  = mk_cw(7'b0000011, 3'b010, 1'b1, 1'b0, 1'b1);
        cw_add = mk_cw(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_ctrl",     ctrl_word_o, 0);
        check("rst_stall",    stall_o, 0);
        @(negedge clk); rst_n = 1;
        next();

        // sw held for 3 wait cycles
        issue(cw_sw, 32'h100, 32'hDEADBEEF, 32'h1000, 3, 0);
        check("sw_be",     be0, 4'b1111);
        check("sw_wdata",  wd0, 32'hDEADBEEF);
        check("sw_addr",   ad0, 32'h100);
        check("sw_writes", n_wr, 4);
        check("sw_stalls", n_stall, 3);
        check("sw_wb_during", n_wb, 0);
        @(negedge clk); check("sw_wb_pulse", wb_valid_o, 1);
        next();
        @(negedge clk); check("sw_wb_single", wb_valid_o, 0);
        next();

        // sb @0x103, lh @0x102
        issue(cw_sb, 32'h103, 32'h000000AB, 32'h1004, 1, 0);
        check("sb_be",    be0, 4'b1000);
        check("sb_wdata", wd0, 32'hAB000000);
        check("sb_writes", n_wr, 2);
        @(negedge clk); next();
        issue(cw_lh, 32'h102, 0, 32'h1008, 0, 32'h5555AAAA);
        check("lh_be",    be0, 4'b1100);
        check("lh_read",  n_rd, 1);
        check("lh_stall", n_stall, 0);
        @(negedge clk);
        check("lh_wb_be",   mem_byte_enable_o, 4'b1100);
        check("lh_r_data",  r_data_o, 32'h5555AAAA);
        next();

        // lw @0x200
        issue(cw_lw, 32'h200, 0, 32'h2000, 1, 32'h12345678);
        @(negedge clk);
        check("lw_r_data",   r_data_o, 32'h12345678);
        check("lw_wb_valid", wb_valid_o, 1);
        check("lw_load_rf",  ctrl_word_o.load_regfile, 1);
        check("lw_pc",       pc_o, 32'h2000);
        check("lw_alu",      alu_o, 32'h200);
        next();

        // three back-to-back adds
        for (int k = 0; k < 3; k++) begin
            set_instr(cw_add, 32'h7 + k, 0, 32'h3000 + 4 * k);
            @(negedge clk);
            check("add_stall", stall_o, 0);
            check("add_req",   dmem_read_o | dmem_write_o, 0);
            if (k > 0) begin
                check("add_wb_valid", wb_valid_o, 1);
                check("add_pc",       pc_o, 32'h3000 + 4 * (k - 1));
            end
            next();
        end
        idle_inputs();
        @(negedge clk);
        check("add_wb_last", wb_valid_o, 1);
        check("add_pc_last", pc_o, 32'h3008);
        check("add_r_data",  r_data_o, 0);
        next();

        // flush in IDLE
        set_instr(cw_lw, 32'h300, 0, 32'h4000);
        flush_i = 1;
        @(negedge clk);
        check("flush_idle_req",   dmem_read_o, 0);
        check("flush_idle_stall", stall_o, 0);
        next(); idle_inputs();
        @(negedge clk); check("flush_idle_bubble", wb_valid_o, 0);
        next();

        // flush in BUSY
        set_instr(cw_lw, 32'h304, 0, 32'h5000);
        @(negedge clk); check("fb_req0", dmem_read_o, 1); next();
        flush_i = 1;
        @(negedge clk); check("fb_req1", dmem_read_o, 1); check("fb_stall1", stall_o, 1); next();
        flush_i = 0;
        @(negedge clk); check("fb_req2", dmem_read_o, 1); check("fb_stall2", stall_o, 1); next();
        dmem_resp_i = 1; dmem_rdata_i = 32'hCAFEF00D;
        @(negedge clk); check("fb_req3", dmem_read_o, 1); check("fb_stall3", stall_o, 0); next();
        idle_inputs();
        @(negedge clk); check("fb_bubble", wb_valid_o, 0); check("fb_r_data", r_data_o, 0); next();
        set_instr(cw_add, 0, 0, 32'h5100);
        @(negedge clk); check("fb_after_stall", stall_o, 0); next();
        idle_inputs();
        @(negedge clk); check("fb_after_wb", wb_valid_o, 1); next();

        // reset while BUSY
        set_instr(cw_lw, 32'h400, 0, 32'h6000);
        @(negedge clk); next();
        #2 rst_n = 0;
        #1;
        check("rb_read",  dmem_read_o, 0);
        check("rb_stall", stall_o, 0);
        check("rb_wb",    wb_valid_o, 0);
        check("rb_ctrl",  ctrl_word_o, 0);
        idle_inputs();
        @(negedge clk); rst_n = 1;
        next();
        @(negedge clk); check("rb_idle_stall", stall_o, 0); next();

        // lw @0x202
        set_instr(cw_lw, 32'h202, 0, 32'h7000);
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        check("mis_req",   dmem_read_o, 0);
        check("mis_stall", stall_o, 0);
        next(); idle_inputs();
        @(negedge clk);
        check("mis_flag",    misalign_o, 1);
        check("mis_wb",      wb_valid_o, 1);
        check("mis_load_rf", ctrl_word_o.load_regfile, 0);
        next();
`else
        dmem_resp_i = 1; dmem_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        check("mis_req", dmem_read_o, 1);
        check("mis_be",  dmem_byte_enable_o, 4'b1111);
        check("mis_addr", dmem_address_o, 32'h200);
        next(); idle_inputs();
        @(negedge clk);
        check("mis_flag",    misalign_o, 0);
        check("mis_load_rf", ctrl_word_o.load_regfile, 1);
        check("mis_r_data",  r_data_o, 32'h0BADF00D);
        next();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
